// File: rtl/iir_biquad_stream.sv
`default_nettype none
// ============================================================================
//  Module   : iir_biquad_stream
//  Purpose  : Direct-form-I biquad IIR filter between two sample FIFOs.
//             A single multiplier is shared across the five MAC terms, so
//             each sample takes one read cycle, five MAC cycles and one
//             write cycle.
//  Config   : define IIR_SAT_EN to clamp the result to the signed
//             DATA_WIDTH range. Without it, the result wraps to the low
//             DATA_WIDTH bits.
//  Revision : 1.0  initial release
// ============================================================================
module iir_biquad_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,   // must be >= 1
  parameter int B0         = 178,
  parameter int B1         = 178,
  parameter int B2         = 0,
  parameter int A1         = -666,
  parameter int A2         = 0,
  parameter bit PRIME_OUT  = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] dout,
  input  logic                         out_full,
  output logic                         out_wr_en
);

  localparam int c_acc_w  = DATA_WIDTH + 3;
  localparam int c_prod_w = 2 * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] c_b0 = DATA_WIDTH'(B0);
  localparam logic signed [DATA_WIDTH-1:0] c_b1 = DATA_WIDTH'(B1);
  localparam logic signed [DATA_WIDTH-1:0] c_b2 = DATA_WIDTH'(B2);
  localparam logic signed [DATA_WIDTH-1:0] c_a1 = DATA_WIDTH'(A1);
  localparam logic signed [DATA_WIDTH-1:0] c_a2 = DATA_WIDTH'(A2);

  // Adding 2**FRAC_BITS-1 to a negative product before the arithmetic
  // shift turns floor division into truncation toward zero.
  localparam logic signed [c_prod_w-1:0] c_bias =
    {{(c_prod_w-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};

  typedef enum logic [1:0] {
    S_PRIME = 2'd0,
    S_READ  = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                         r_state;
  logic signed [DATA_WIDTH-1:0]   r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [DATA_WIDTH-1:0]   r_dout;
  logic signed [c_acc_w-1:0]      r_acc;
  logic        [2:0]              r_mac_idx;

  logic signed [DATA_WIDTH-1:0]   w_coef;
  logic signed [DATA_WIDTH-1:0]   w_oper;
  logic                           w_sub;
  logic signed [c_prod_w-1:0]     w_prod;
  logic signed [c_prod_w-1:0]     w_biased;
  logic signed [c_acc_w-1:0]      w_term;
  logic signed [c_acc_w-1:0]      w_acc_next;
  logic signed [DATA_WIDTH-1:0]   w_result;

  // FIFO strobes are gated by reset so an in-flight sample is never pushed.
  assign in_rd_en  = !reset && (r_state == S_READ) && !in_empty;
  assign out_wr_en = !reset && ((r_state == S_PRIME) || (r_state == S_OUT)) && !out_full;
  assign dout      = r_dout;

  // Select the coefficient/operand pair for the current MAC step.
  always_comb begin
    w_coef = c_b0;
    w_oper = r_x0;
    w_sub  = 1'b0;
    case (r_mac_idx)
      3'd0: begin w_coef = c_b0; w_oper = r_x0; w_sub = 1'b0; end
      3'd1: begin w_coef = c_b1; w_oper = r_x1; w_sub = 1'b0; end
      3'd2: begin w_coef = c_b2; w_oper = r_x2; w_sub = 1'b0; end
      3'd3: begin w_coef = c_a1; w_oper = r_y1; w_sub = 1'b1; end
      default: begin w_coef = c_a2; w_oper = r_y2; w_sub = 1'b1; end
    endcase
  end

  assign w_prod     = c_prod_w'(w_coef) * c_prod_w'(w_oper);
  assign w_biased   = w_prod + (w_prod[c_prod_w-1] ? c_bias : '0);
  assign w_term     = c_acc_w'(w_biased >>> FRAC_BITS);
  assign w_acc_next = w_sub ? (r_acc - w_term) : (r_acc + w_term);

`ifdef IIR_SAT_EN
  localparam logic signed [c_acc_w-1:0] c_max =
    {{4{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_min =
    {{4{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp the final accumulator to the signed output range.
  always_comb begin
    w_result = w_acc_next[DATA_WIDTH-1:0];
    if (w_acc_next > c_max) begin
      w_result = DATA_WIDTH'(c_max);
    end else if (w_acc_next < c_min) begin
      w_result = DATA_WIDTH'(c_min);
    end
  end
`else
  // Two's-complement wrap of the final accumulator.
  always_comb begin
    w_result = w_acc_next[DATA_WIDTH-1:0];
  end
`endif

  // Read / MAC / write sequencer. Histories shift only on the actual write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= PRIME_OUT ? S_PRIME : S_READ;
      r_x0      <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_y1      <= '0;
      r_y2      <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
      r_mac_idx <= '0;
    end else begin
      case (r_state)
        S_PRIME: begin
          if (!out_full) begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (!in_empty) begin
            r_x0      <= din;
            r_acc     <= '0;
            r_mac_idx <= '0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_mac_idx == 3'd4) begin
            r_dout  <= w_result;
            r_state <= S_OUT;
          end else begin
            r_mac_idx <= r_mac_idx + 3'd1;
          end
        end
        S_OUT: begin
          if (!out_full) begin
            r_x2    <= r_x1;
            r_x1    <= r_x0;
            r_y2    <= r_y1;
            r_y1    <= r_dout;
            r_state <= S_READ;
          end
        end
        default: begin
          r_state <= S_READ;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
